mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access (MEM) pipeline stage. Sits between the EX stage and the WB stage of the 5-stage in-order core.
- Latches the EX result bundle and receives the synchronous data-SRAM read data, which arrives one cycle after the EX-stage request.
- Aligns and extends load data, then produces the WB bundle plus a forwarding/hazard bundle for the ID stage.
- Holds SRAM read data in a local buffer so a WB back-pressure stall cannot lose it.

Parameters:
- ES2MS_BUS_W, 76, width of the EX→MEM bundle.
- MS2WS_BUS_W, 70, width of the MEM→WB bundle.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- ms_allowin  out  1  MEM can accept a new instruction this cycle.
- es2ms_valid  in  1  EX presents a valid instruction.
- es2ms_bus  in  76  {ld_op[4:0] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, es_pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}.
- data_sram_rdata  in  32  SRAM read data; valid the cycle after the EX request.
- ws_allowin  in  1  WB can accept.
- ms2ws_valid  out  1  MEM presents a valid instruction to WB.
- ms2ws_bus  out  70  {ms_pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- ms_rf_zip  out  39  {res_from_mem&ms_valid, rf_we&ms_valid, rf_waddr, final_result}; sent to ID for hazard detection and forwarding.

Behaviour:
- Reset: asynchronous on resetn low; all state clears immediately.
  - ms_valid=0, bus register=0, ms_fresh=0, rdata_buf=0.
  - Resulting outputs: ms2ws_valid=0, ms_allowin=1, ms_rf_zip=0, ms2ws_bus=0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = ~ms_valid | ws_allowin.
  - ms2ws_valid = ms_valid.
  - Each clock edge: ms_valid <= es2ms_valid & ms_allowin when ms_allowin=1; otherwise ms_valid is held.
  - The bus register loads only on es2ms_valid & ms_allowin.
- Latency: one cycle per instruction; no bubbles are inserted by this stage.
- Read-data capture:
  - ms_fresh is set on the edge that loads a new instruction and cleared on the next edge.
  - rdata_buf <= data_sram_rdata on every edge where ms_fresh=1.
  - Effective read data = ms_fresh ? data_sram_rdata : rdata_buf.
  - This keeps the correct data through any number of stall cycles.
- Load alignment (combinational), with a = alu_result[1:0]:
  - ld_w: word as-is; a is ignored.
  - ld_b / ld_bu: byte a; ld_b sign-extends, ld_bu zero-extends.
  - ld_h / ld_hu: halfword selected by a[1]; a[0] is ignored, no misalignment trap.
  - Exactly one ld_op bit is set when res_from_mem=1. When res_from_mem=0, ld_op is ignored.
- Final result: final_result = res_from_mem ? aligned_load : alu_result.
  - rf_wdata = final_result.
  - rf_we and the ms_rf_zip flags are gated by ms_valid.
- Simultaneous events:
  - WB accepts and EX offers on the same edge: the new instruction replaces the old one. ms_fresh re-arms and the buffer re-captures on the following edge.
  - WB stalled while EX offers: EX is refused and the held instruction is unchanged.
- Reset mid-stall: the instruction is discarded with no partial writeback.

Decomposition:
- Shared package (e.g. cpu_defs):
  - bus widths ES2MS_BUS_W, MS2WS_BUS_W;
  - RF_ZIP_W=39;
  - ld_op bit indices LD_B..LD_W.
- One combinational sub-module, mem_load_align:
  - inputs: rdata[31:0], addr_lo[1:0], ld_op[4:0];
  - output: aligned[31:0].
- Handshake, ms_fresh and buffer logic stay in mem_stage.

Test Plan:
1. Non-load ALU op: bus{res_from_mem=0, rf_we=1, waddr=5, alu_result=0x1234_5678}, ws_allowin=1 → next cycle ms2ws_bus wdata=0x12345678, waddr=5, ms_rf_zip[38]=0, ms_rf_zip[37]=1.
2. Byte loads with rdata=0x80FF_7F01:
   - ld_b, addr=..3 → wdata=0xFFFFFF80;
   - ld_bu, addr=..3 → wdata=0x00000080;
   - ld_b, addr=..1 → wdata=0x0000007F.
3. Half loads with rdata=0x8001_F00F:
   - ld_h, addr=..2 → wdata=0xFFFF8001;
   - ld_hu, addr=..0 → wdata=0x0000F00F;
   - ld_w → wdata=0x8001F00F.
4. Stall holds data: ld_w with rdata=0xCAFEBABE in the fresh cycle; ws_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF → ms2ws_valid=1, wdata=0xCAFEBABE throughout, ms_allowin=0; EX is not accepted until ws_allowin=1.
5. Back-to-back loads with ws_allowin=1 and rdata 0x11111111 then 0x22222222 on consecutive cycles → WB sees each value in order with no bubble.
6. Reset mid-stall: assert resetn=0 asynchronously during case 4 → ms2ws_valid and ms_rf_zip are 0 immediately (before the next edge) and ms_allowin=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bundle widths, ld_op bit
// positions and the packed layout of the EX->MEM and MEM->WB bundles.
package mem_stage_pkg;

  localparam int ES2MS_BUS_W = 76;
  localparam int MS2WS_BUS_W = 70;
  localparam int RF_ZIP_W    = 39;

  // ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;

  typedef struct packed {
    logic [4:0]  ld_op;
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } es2ms_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } ms2ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and bundle signals around the MEM stage (EX side, SRAM return,
// WB side and the ID forwarding bundle).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                   es2ms_valid;
  logic [ES2MS_BUS_W-1:0] es2ms_bus;
  logic [31:0]            data_sram_rdata;
  logic                   ws_allowin;
  logic                   ms_allowin;
  logic                   ms2ws_valid;
  logic [MS2WS_BUS_W-1:0] ms2ws_bus;
  logic [RF_ZIP_W-1:0]    ms_rf_zip;

  modport master (
    output es2ms_valid, es2ms_bus, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip
  );

  modport slave (
    input  es2ms_valid, es2ms_bus, data_sram_rdata, ws_allowin,
    output ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip
  );

endinterface

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the byte/halfword addressed by addr_lo and
// sign- or zero-extends it; halfword loads ignore addr_lo[0].
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [4:0]  ld_op,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    aligned = rdata;
    if (ld_op[LD_B])       aligned = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) aligned = {24'h0, byte_sel};
    else if (ld_op[LD_H])  aligned = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) aligned = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, buffers the one-cycle-late SRAM
// read data across WB stalls, aligns loads and drives the WB/forwarding bundles.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave ms_if
);

  es2ms_t      ms_bus;
  logic        ms_valid;
  logic        ms_fresh;
  logic [31:0] rdata_buf;
  logic [31:0] rdata_eff;
  logic [31:0] aligned;
  logic [31:0] final_result;
  logic        ms_allowin;
  logic        accept;

  assign ms_allowin = ~ms_valid | ms_if.ws_allowin;
  assign accept     = ms_if.es2ms_valid & ms_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      ms_fresh  <= 1'b0;
      ms_bus    <= '0;
      rdata_buf <= 32'h0;
    end else begin
      if (ms_allowin) ms_valid <= ms_if.es2ms_valid;
      ms_fresh <= accept;
      // SRAM data is only valid in the first cycle; keep it for any stall
      if (ms_fresh) rdata_buf <= ms_if.data_sram_rdata;
      if (accept) ms_bus <= es2ms_t'(ms_if.es2ms_bus);
    end
  end

  assign rdata_eff = ms_fresh ? ms_if.data_sram_rdata : rdata_buf;

  mem_load_align u_align (
    .rdata   (rdata_eff),
    .addr_lo (ms_bus.alu_result[1:0]),
    .ld_op   (ms_bus.ld_op),
    .aligned (aligned)
  );

  assign final_result = ms_bus.res_from_mem ? aligned : ms_bus.alu_result;

  assign ms_if.ms_allowin  = ms_allowin;
  assign ms_if.ms2ws_valid = ms_valid;
  assign ms_if.ms2ws_bus   = {ms_bus.pc, ms_bus.rf_we & ms_valid,
                              ms_bus.rf_waddr, final_result};
  assign ms_if.ms_rf_zip   = {ms_bus.res_from_mem & ms_valid, ms_bus.rf_we & ms_valid,
                              ms_bus.rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized traffic checked every
// cycle against a transaction-level model of the stage.
module tb_mem_stage;

  logic clk;
  logic resetn;
  mem_stage_if ms_if ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ms_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nmis = 0;
  logic run_chk = 1'b0;

  // model: the instruction held in MEM and the word it loaded
  logic        m_valid = 1'b0;
  logic [75:0] m_bus   = '0;
  logic        m_have  = 1'b0;
  logic [31:0] m_data  = '0;

  task automatic check(input string nm, input logic [69:0] act, input logic [69:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [75:0] mkbus(input logic [4:0] op, input logic [31:0] pc,
                                        input logic rfm, input logic we,
                                        input logic [4:0] wa, input logic [31:0] alu);
    return {op, pc, rfm, we, wa, alu};
  endfunction

  // expected writeback value from the load rules, in plain arithmetic
  function automatic logic [31:0] exp_result(input logic [75:0] b, input logic [31:0] d);
    logic [4:0]  op;
    logic [31:0] alu;
    int unsigned sh, bv, hv;
    op  = b[75:71];
    alu = b[31:0];
    if (!b[38]) return alu;
    sh = 32'(alu[1:0]) * 8;
    bv = (d >> sh) & 32'hFF;
    hv = (alu[1] ? (d >> 16) : d) & 32'hFFFF;
    if (op[4]) return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
    if (op[3]) return bv;
    if (op[2]) return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
    if (op[1]) return hv;
    return d;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
    end else begin
      if (m_valid && !m_have) begin
        m_data = ms_if.data_sram_rdata;
        m_have = 1'b1;
      end
      if (!m_valid || ms_if.ws_allowin) begin
        if (ms_if.es2ms_valid) begin
          m_bus   = ms_if.es2ms_bus;
          m_valid = 1'b1;
          m_have  = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ew;
    if (resetn && run_chk) begin
      check("allowin", 70'(ms_if.ms_allowin), 70'(!m_valid || ms_if.ws_allowin));
      check("valid", 70'(ms_if.ms2ws_valid), 70'(m_valid));
      if (m_valid) begin
        ew = exp_result(m_bus, m_have ? m_data : ms_if.data_sram_rdata);
        check("ms2ws_bus", ms_if.ms2ws_bus, {m_bus[70:39], m_bus[37], m_bus[36:32], ew});
        check("rf_zip", 70'(ms_if.ms_rf_zip), 70'({m_bus[38], m_bus[37], m_bus[36:32], ew}));
      end else begin
        check("idle_flags", 70'({ms_if.ms2ws_bus[37], ms_if.ms_rf_zip[38:37]}), 70'(0));
      end
    end
  end

  // called at posedge+1; leaves at the following negedge
  task automatic drive(input logic v, input logic [75:0] b, input logic [31:0] rd, input logic ws);
    ms_if.es2ms_valid     = v;
    ms_if.es2ms_bus       = b;
    ms_if.data_sram_rdata = rd;
    ms_if.ws_allowin      = ws;
    #4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dir_load(input string nm, input logic [4:0] op, input logic [1:0] a,
                          input logic [31:0] rd, input logic [31:0] req);
    drive(1'b1, mkbus(op, 32'h1c00_0100, 1'b1, 1'b1, 5'd7, 32'h0000_1000 | 32'(a)), 32'h0, 1'b1);
    step();
    drive(1'b0, 76'h0, rd, 1'b1);
    check(nm, 70'(ms_if.ms2ws_bus[31:0]), 70'(req));
    step();
  endtask

  localparam logic [4:0] OP_B = 5'b10000, OP_BU = 5'b01000, OP_H = 5'b00100,
                         OP_HU = 5'b00010, OP_W = 5'b00001;

  initial begin
    logic [75:0] bus_a, bus_b;
    resetn                = 1'b0;
    ms_if.es2ms_valid     = 1'b0;
    ms_if.es2ms_bus       = '0;
    ms_if.data_sram_rdata = '0;
    ms_if.ws_allowin      = 1'b0;
    #2;
    check("rst_allowin", 70'(ms_if.ms_allowin), 70'(1));
    check("rst_valid", 70'(ms_if.ms2ws_valid), 70'(0));
    check("rst_zip", 70'(ms_if.ms_rf_zip), 70'(0));
    check("rst_bus", ms_if.ms2ws_bus, 70'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    run_chk = 1'b1;

    // non-load ALU result
    drive(1'b1, mkbus(5'b10101, 32'h1c00_0000, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'hFFFF_FFFF, 1'b1);
    step();
    drive(1'b0, 76'h0, 32'hFFFF_FFFF, 1'b1);
    check("alu_wdata", 70'(ms_if.ms2ws_bus[31:0]), 70'h1234_5678);
    check("alu_waddr", 70'(ms_if.ms2ws_bus[36:32]), 70'd5);
    check("alu_zip_flags", 70'(ms_if.ms_rf_zip[38:37]), 70'b01);
    step();

    dir_load("ld_b_a3",  OP_B,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
    dir_load("ld_bu_a3", OP_BU, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
    dir_load("ld_b_a1",  OP_B,  2'd1, 32'h80FF_7F01, 32'h0000_007F);
    dir_load("ld_h_a2",  OP_H,  2'd2, 32'h8001_F00F, 32'hFFFF_8001);
    dir_load("ld_hu_a0", OP_HU, 2'd0, 32'h8001_F00F, 32'h0000_F00F);
    dir_load("ld_hu_a1", OP_HU, 2'd1, 32'h8001_F00F, 32'h0000_F00F);
    dir_load("ld_w",     OP_W,  2'd2, 32'h8001_F00F, 32'h8001_F00F);

    // WB stall holds the first-cycle read data and refuses EX
    bus_a = mkbus(OP_W, 32'h1c00_0200, 1'b1, 1'b1, 5'd9, 32'h0000_2000);
    bus_b = mkbus(5'b0, 32'h1c00_0204, 1'b0, 1'b1, 5'd10, 32'h0000_00AA);
    drive(1'b1, bus_a, 32'h0, 1'b1);
    step();
    drive(1'b1, bus_b, 32'hCAFE_BABE, 1'b0);
    check("stall_wdata0", 70'(ms_if.ms2ws_bus[31:0]), 70'hCAFE_BABE);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bus_b, 32'hDEAD_BEEF, 1'b0);
      check("stall_wdata", 70'(ms_if.ms2ws_bus[31:0]), 70'hCAFE_BABE);
      check("stall_allowin", 70'(ms_if.ms_allowin), 70'(0));
      check("stall_pc", 70'(ms_if.ms2ws_bus[69:38]), 70'h1c00_0200);
      step();
    end
    drive(1'b1, bus_b, 32'hDEAD_BEEF, 1'b1);
    check("release_wdata", 70'(ms_if.ms2ws_bus[31:0]), 70'hCAFE_BABE);
    step();
    drive(1'b0, 76'h0, 32'h5555_5555, 1'b1);
    check("after_stall_pc", 70'(ms_if.ms2ws_bus[69:38]), 70'h1c00_0204);
    step();

    // back-to-back loads, no bubble
    drive(1'b1, mkbus(OP_W, 32'h1c00_0300, 1'b1, 1'b1, 5'd3, 32'h0), 32'h0, 1'b1);
    step();
    drive(1'b1, mkbus(OP_W, 32'h1c00_0304, 1'b1, 1'b1, 5'd4, 32'h4), 32'h1111_1111, 1'b1);
    check("b2b_first", 70'({ms_if.ms2ws_valid, ms_if.ms2ws_bus[31:0]}), 70'h1_1111_1111);
    step();
    drive(1'b0, 76'h0, 32'h2222_2222, 1'b1);
    check("b2b_second", 70'({ms_if.ms2ws_valid, ms_if.ms2ws_bus[69:38], ms_if.ms2ws_bus[31:0]}),
          {1'b1, 32'h1c00_0304, 32'h2222_2222});
    step();

    // asynchronous reset in the middle of a stall
    drive(1'b1, mkbus(OP_W, 32'h1c00_0400, 1'b1, 1'b1, 5'd11, 32'h0), 32'h0, 1'b1);
    step();
    drive(1'b0, 76'h0, 32'hCAFE_BABE, 1'b0);
    step();
    drive(1'b0, 76'h0, 32'hDEAD_BEEF, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", 70'(ms_if.ms2ws_valid), 70'(0));
    check("rst_mid_zip", 70'(ms_if.ms_rf_zip), 70'(0));
    check("rst_mid_allowin", 70'(ms_if.ms_allowin), 70'(1));
    step();
    resetn = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rfm;
      logic [4:0]  op;
      rfm = 1'($urandom_range(0, 1));
      op  = rfm ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
      drive(($urandom_range(0, 3) != 0),
            mkbus(op, $urandom, rfm, 1'($urandom), 5'($urandom), $urandom),
            $urandom, ($urandom_range(0, 2) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
